// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 Booth) and divide (restoring).
// Define MULTDIV_DIV_EN to build the divider; otherwise any divide request
// completes immediately with result = 0 and exception = 1.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_rdy,
  output logic             busy
);

  localparam int unsigned ACC_W = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;      // {hi, lo, q-1} for multiply; {rem, quotient} for divide
  logic [WIDTH-1:0] mcand, mcand_nxt;  // multiplicand, or divisor magnitude
  logic             div_zero, div_zero_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             exception_nxt, result_rdy_nxt, busy_nxt;

  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH-1:0] product;
  logic               prod_ovf;

`ifdef MULTDIV_DIV_EN
  logic             op_div, op_div_nxt;
  logic             neg_q, neg_q_nxt;
  logic [WIDTH:0]   div_shift, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Restoring divide step plus operand magnitudes for the start load
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mcand});
    div_rem   = div_ge ? (div_shift - {1'b0, mcand}) : div_shift;
    a_mag     = operand_a[WIDTH-1] ? ((~operand_a) + WIDTH'(1)) : operand_a;
    b_mag     = operand_b[WIDTH-1] ? ((~operand_b) + WIDTH'(1)) : operand_b;
  end
`endif

  // Booth add/subtract into the upper half with one bit of headroom, then product overflow
  always_comb begin
    booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]} - {mcand[WIDTH-1], mcand};
      default: ;
    endcase
    product  = acc[ACC_W-1:1];
    prod_ovf = ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
  end

  // Next-state, datapath and output logic; a start request overrides any state
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_nxt       = acc;
    mcand_nxt     = mcand;
    div_zero_nxt  = div_zero;
    result_nxt    = result;
    exception_nxt = exception;
`ifdef MULTDIV_DIV_EN
    op_div_nxt    = op_div;
    neg_q_nxt     = neg_q;
`endif

    case (state)
      MULT: begin
        acc_nxt = {booth_sum, acc[WIDTH:1]};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
`ifdef MULTDIV_DIV_EN
      DIV: begin
        acc_nxt = {div_rem, acc[WIDTH-2:0], div_ge};
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
        if (div_zero) begin
          result_nxt    = '0;
          exception_nxt = 1'b1;
`ifdef MULTDIV_DIV_EN
        end else if (op_div) begin
          result_nxt    = neg_q ? ((~acc[WIDTH-1:0]) + WIDTH'(1)) : acc[WIDTH-1:0];
          exception_nxt = ~neg_q & acc[WIDTH-1];
`endif
        end else begin
          result_nxt    = product[WIDTH-1:0];
          exception_nxt = prod_ovf;
        end
      end
      default: ;
    endcase

    if (start_mult) begin
      state_nxt    = MULT;
      cnt_nxt      = '0;
      acc_nxt      = {WIDTH'(0), operand_b, 1'b0};
      mcand_nxt    = operand_a;
      div_zero_nxt = 1'b0;
`ifdef MULTDIV_DIV_EN
      op_div_nxt   = 1'b0;
`endif
    end else if (start_div) begin
      cnt_nxt = '0;
`ifdef MULTDIV_DIV_EN
      op_div_nxt   = 1'b1;
      neg_q_nxt    = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      mcand_nxt    = b_mag;
      acc_nxt      = {(WIDTH + 1)'(0), a_mag};
      div_zero_nxt = (operand_b == '0);
      state_nxt    = (operand_b == '0) ? DONE : DIV;
`else
      div_zero_nxt = 1'b1;
      state_nxt    = DONE;
`endif
    end

    result_rdy_nxt = (state == DONE);
    busy_nxt       = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      div_zero   <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
      busy       <= 1'b0;
`ifdef MULTDIV_DIV_EN
      op_div     <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      mcand      <= mcand_nxt;
      div_zero   <= div_zero_nxt;
      result     <= result_nxt;
      exception  <= exception_nxt;
      result_rdy <= result_rdy_nxt;
      busy       <= busy_nxt;
`ifdef MULTDIV_DIV_EN
      op_div     <= op_div_nxt;
      neg_q      <= neg_q_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Testbench for multdiv_unit: vector table plus hand-written restart,
// back-to-back and reset sequences; results checked through a scoreboard queue.
module tb_multdiv_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start_mult, start_div;
  logic [W-1:0] operand_a, operand_b;
  logic [W-1:0] result;
  logic         exception, result_rdy, busy;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic         sd;
    logic [W-1:0] res;
    logic         exc;
    int           lat;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    string        name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start_mult (start_mult),
    .start_div  (start_div),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .result     (result),
    .exception  (exception),
    .result_rdy (result_rdy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic sd, input logic [W-1:0] res, input logic exc,
                         input int lat, input string name);
    vec_t v;
    v.a = a; v.b = b; v.sm = sm; v.sd = sd;
    v.res = res; v.exc = exc; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic expect_push(input logic [W-1:0] res, input logic exc, input string name);
    exp_t e;
    e.res = res; e.exc = exc; e.name = name;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle start pulse; operands are scrambled afterwards
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input logic sd);
    operand_a  = a;
    operand_b  = b;
    start_mult = sm;
    start_div  = sd;
    @(negedge clk);
    start_mult = 1'b0;
    start_div  = 1'b0;
    operand_a  = $urandom;
    operand_b  = $urandom;
  endtask

  // Called one negedge after the start edge; measures edges from start to result_rdy
  task automatic wait_rdy(input int lat, input string name);
    int cyc = 0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    while (result_rdy !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, 64'(cyc), 64'(lat));
    check({name, "_busy_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({name, "_pulse"}, 64'(result_rdy), 64'd0);
  endtask

  // Scoreboard: every result_rdy pops one expected record
  always @(negedge clk) begin
    if (clr_n === 1'b1 && result_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got result_rdy=1 result=0x%0h, expected no completion", result);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_result"}, 64'(result), 64'(mon_e.res));
        check({mon_e.name, "_exc"}, 64'(exception), 64'(mon_e.exc));
      end
    end
  end

  initial begin
    logic [W-1:0]        ra, rb;
    logic signed [63:0]  pa, pb, prod;
    int                  hold_bad;
    int                  rdy_seen;

    clr_n = 1'b0; start_mult = 1'b0; start_div = 1'b0;
    operand_a = '0; operand_b = '0;

    add_vec(32'd7,        32'hFFFFFFFA, 1'b1, 1'b0, 32'hFFFFFFD6, 1'b0, 33, "mul_7x-6");
    add_vec(32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 1'b1, 33, "mul_ovf_2p32");
    add_vec(32'd2,        32'd3,        1'b1, 1'b1, 32'd6,        1'b0, 33, "mul_both_starts");
    add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd1,        1'b0, 33, "mul_-1x-1");
    add_vec(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1'b1, 33, "mul_min_x-1");
    add_vec(32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 33, "mul_min_x_min");
    add_vec(32'h80000000, 32'd1,        1'b1, 1'b0, 32'h80000000, 1'b0, 33, "mul_min_x1");
    add_vec(32'h7FFFFFFF, 32'd1,        1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 33, "mul_max_x1");
    add_vec(32'd5,        32'd0,        1'b0, 1'b1, 32'd0,        1'b1, 1,  "div_5by0");
`ifdef MULTDIV_DIV_EN
    add_vec(32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, 32'hFFFFFFFD, 1'b0, 33, "div_-7by2");
    add_vec(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 33, "div_min_by-1");
    add_vec(32'd100,      32'd7,        1'b0, 1'b1, 32'd14,       1'b0, 33, "div_100by7");
    add_vec(32'd7,        32'hFFFFFFF9, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 33, "div_7by-7");
    add_vec(32'h80000000, 32'd1,        1'b0, 1'b1, 32'h80000000, 1'b0, 33, "div_min_by1");
    add_vec(32'd3,        32'd5,        1'b0, 1'b1, 32'd0,        1'b0, 33, "div_3by5");
`else
    add_vec(32'd5,        32'd3,        1'b0, 1'b1, 32'd0,        1'b1, 1,  "div_off_5by3");
    add_vec(32'hFFFFFFF9, 32'd2,        1'b0, 1'b1, 32'd0,        1'b1, 1,  "div_off_-7by2");
`endif

    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'd0);
    check("rst_exc", 64'(exception), 64'd0);
    check("rst_rdy", 64'(result_rdy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    clr_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      expect_push(vecs[i].res, vecs[i].exc, vecs[i].name);
      issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].sd);
      wait_rdy(vecs[i].lat, vecs[i].name);
    end

    // Random multiplies against a 64-bit reference product
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra = W'($signed(ra[15:0]));
        rb = W'($signed(rb[14:0]));
      end
      pa = {{32{ra[W-1]}}, ra};
      pb = {{32{rb[W-1]}}, rb};
      prod = pa * pb;
      expect_push(prod[W-1:0], (prod != {{32{prod[W-1]}}, prod[W-1:0]}), "mul_rand");
      issue(ra, rb, 1'b1, 1'b0);
      wait_rdy(33, "mul_rand");
    end

`ifdef MULTDIV_DIV_EN
    // Random divides against SV signed division (truncates toward zero)
    for (int i = 0; i < 4; i++) begin
      int sa, sbv;
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($signed(rb[9:0])) : $urandom;
      rb = $urandom_range(1, 2000);
      if (i % 2 == 1) rb = -rb;
      sa = int'(ra);
      sbv = int'(rb);
      expect_push(W'(sa / sbv), 1'b0, "div_rand");
      issue(ra, rb, 1'b0, 1'b1);
      wait_rdy(33, "div_rand");
    end
`endif

    // Restart at E10: only the second operation completes, 33 edges after the restart
    issue(32'd3, 32'd4, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    expect_push(32'd25, 1'b0, "restart");
    issue(32'd5, 32'd5, 1'b1, 1'b0);
    wait_rdy(33, "restart");

    // Back-to-back start at the DONE edge, result held during the second operation
    expect_push(32'hFFFFFFD6, 1'b0, "b2b_first");
    issue(32'd7, 32'hFFFFFFFA, 1'b1, 1'b0);
    repeat (32) @(negedge clk);
    check("b2b_pre_rdy", 64'(result_rdy), 64'd0);
    expect_push(32'h2468ACF0, 1'b0, "b2b_second");
    issue(32'h12345678, 32'd2, 1'b1, 1'b0);
    check("b2b_first_rdy", 64'(result_rdy), 64'd1);
    check("b2b_busy", 64'(busy), 64'd1);
    hold_bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (result !== 32'hFFFFFFD6 || result_rdy !== 1'b0 || busy !== 1'b1) hold_bad++;
    end
    check("b2b_hold", 64'(hold_bad), 64'd0);
    @(negedge clk);
    check("b2b_second_rdy", 64'(result_rdy), 64'd1);
    @(negedge clk);
    check("b2b_second_pulse", 64'(result_rdy), 64'd0);

    // Asynchronous reset mid-multiply discards the operation
    issue(32'h00010001, 32'h00010001, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_exc", 64'(exception), 64'd0);
    check("midrst_rdy", 64'(result_rdy), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_rdy !== 1'b0 || busy !== 1'b0) rdy_seen++;
    end
    check("midrst_quiet", 64'(rdy_seen), 64'd0);
    check("midrst_result_after", 64'(result), 64'd0);

    expect_push(32'd6, 1'b0, "post_rst");
    issue(32'd2, 32'd3, 1'b1, 1'b0);
    wait_rdy(33, "post_rst");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
